spi_exe_unit_2: RTL and testbench
=================================

Name: spi_exe_unit_2

Overview:
- Parametrised second-generation SPI execution unit: an SPI slave that deserialises one command frame (opcode, operand A, operand B) from MOSI and executes it in a single cycle.
- Serialises result plus flags back on MISO within the same chip-select window.
- Adds over gen 1: configurable operand/opcode width, frame-abort detection, illegal-opcode error, a completion pulse and a busy indicator.

Parameters:
- M, 8, operand and result width in bits (≥4).
- N, 4, opcode width in bits (≥4).
- F, 4, flag width (fixed field layout; do not change).

Ports:
- i_clk_p  in  1  SPI clock; all logic on rising edge.
- i_rst_n  in  1  reset; synchronous and active-low.
- i_cs_n  in  1  chip select, active-low.
- i_mosi  in  1  serial data in, MSB first.
- o_miso  out  1  serial data out, MSB first; 0 outside TX.
- o_busy  out  1  high in RX, EXEC and TX.
- o_frame_done  out  1  one-cycle pulse after the last TX bit.
- o_err  out  1  status of the last frame; cleared at frame start.

Behaviour:
- Reset (i_rst_n=0 at an edge): state IDLE, all shift registers and counters 0, o_miso=0, o_busy=0, o_frame_done=0, o_err=0. Reset wins over every other event, including mid-RX or mid-TX.
- Inbound frame: L_IN = N+2M bits, ordered {opcode[N-1:0], A[M-1:0], B[M-1:0]}, MSB first.
- Outbound frame: L_OUT = M+F bits, ordered {result[M-1:0], flags[3:0]}.
- Flags: [3]=ZF, [2]=CF, [1]=OF, [0]=SF.
- IDLE: on an edge with i_cs_n=0, sample i_mosi as bit 0, clear o_err, set bit count=1, go to RX.
- RX: sample i_mosi every edge. When the count reaches L_IN, the last bit is sampled and the FSM goes to EXEC.
- EXEC (1 cycle): compute result/flags from the latched fields, load the output shifter, then go to TX.
- TX (L_OUT cycles): o_miso = output shifter MSB, which is combinational from the register and gated by state==TX. Shift each edge. After bit L_OUT-1, pulse o_frame_done for one cycle and go to WAIT_CS.
- WAIT_CS: MISO=0. Return to IDLE on the first edge with i_cs_n=1. Holding cs low never starts a second frame.
- Abort: i_cs_n=1 on any edge in RX, EXEC or TX sets o_err=1 and returns to IDLE. No o_frame_done, no result driven. Any partial frame is discarded.
- Latency at defaults: 20 RX cycles, 1 EXEC cycle, 12 TX cycles. First result bit appears on the cycle after EXEC.
- Operations (low opcode values; the rest are illegal):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 NOT A.
  - 6 SHL A by B[$clog2(M)-1:0].
  - 7 SHR (logical), same shift amount.
  - 8 CMP: flags of A-B, result=A.
- Arithmetic (M-bit, two's complement):
  - ADD: CF = carry out of M+1-bit sum; OF = signed overflow.
  - SUB/CMP: CF = borrow (A<B unsigned); OF = signed overflow.
  - Logic and shift ops: CF=OF=0.
  - All ops: ZF = (result==0); SF = result[M-1].
- Illegal opcode: result=0, flags=0, o_err=1. Frame still completes normally with o_frame_done.

Decomposition:
- Package spi_exe_pkg:
  - opcode enum (OP_ADD..OP_CMP)
  - flag index constants (FLAG_ZF, FLAG_CF, FLAG_OF, FLAG_SF)
  - FSM state enum (IDLE, RX, EXEC, TX, WAIT_CS)
  - width helpers L_IN/L_OUT as functions of M, N
- Sub-module spi_exe_alu: combinational, parametrised M/N, outputs result, flags and illegal. Top level holds FSM, counters and shift registers.

Test Plan:
- ADD 0x7F+0x01 (defaults), cs low 33 cycles → MISO bits 0x80 then 4'b0011; o_frame_done pulses at cycle 33; o_err=0.
- SUB 0x05-0x05, then CMP 0x03 vs 0x09 → first frame 0x00/4'b1000; second frame 0x03/4'b0100 (borrow, result positive so SF=0).
- Abort: cs high after 10 RX bits → o_err=1, no o_frame_done, MISO stays 0; following full ADD 0x01+0x02 frame returns 0x03/4'b0000 with o_err cleared.
- Illegal opcode 0xF with A=0xAA, B=0x55 → MISO 0x00/4'b0000, o_err=1, o_frame_done pulses.
- cs held low 40 cycles after a complete frame → only one o_frame_done, MISO=0 after TX. Reset asserted mid-TX → next edge all outputs 0, state IDLE.
- Param M=16, N=4: SHL 0x0001 by B=15 → 0x8000, flags 4'b0001; frame length 36 in, 20 out.

Source files
------------

// File: rtl/spi_exe_pkg.sv
// Shared definitions for the SPI execution unit.
// Contents: opcode encoding, flag bit positions, FSM state codes and
// frame-length helpers that derive bit counts from the operand/opcode widths.
package spi_exe_pkg;

    // Legal opcodes. Any other value of the opcode field is reported as illegal.
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_CMP = 4'd8
    } opcode_e;

    // Bit positions inside the 4-bit flag field.
    localparam int FLAG_ZF = 3;
    localparam int FLAG_CF = 2;
    localparam int FLAG_OF = 1;
    localparam int FLAG_SF = 0;

    // FSM state codes.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RX      = 3'd1;
    localparam logic [2:0] ST_EXEC    = 3'd2;
    localparam logic [2:0] ST_TX      = 3'd3;
    localparam logic [2:0] ST_WAIT_CS = 3'd4;

    // Inbound frame: opcode followed by two operands.
    function automatic int calc_l_in(input int m, input int n);
        return n + 2 * m;
    endfunction

    // Outbound frame: result followed by flags.
    function automatic int calc_l_out(input int m, input int f);
        return m + f;
    endfunction

endpackage

// File: rtl/spi_exe_alu.sv
// Combinational ALU for the SPI execution unit.
// Ports:
//   i_op      opcode field of the received frame
//   i_a, i_b  operands (B's low $clog2(M) bits are the shift amount)
//   o_result  M-bit result (0 for illegal opcodes)
//   o_flags   {ZF, CF, OF, SF} (all 0 for illegal opcodes)
//   o_illegal opcode outside the supported set
module spi_exe_alu
    import spi_exe_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 4
) (
    input  logic [N-1:0] i_op,
    input  logic [M-1:0] i_a,
    input  logic [M-1:0] i_b,
    output logic [M-1:0] o_result,
    output logic [3:0]   o_flags,
    output logic         o_illegal
);
    localparam int SW = $clog2(M);

    logic [M:0]    w_sum;
    logic [M:0]    w_diff;
    logic [SW-1:0] w_sh;
    logic [M-1:0]  w_res;
    logic          w_cf;
    logic          w_of;
    logic          w_ill;
    logic          w_sub_of;

    assign w_sum    = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff   = {1'b0, i_a} - {1'b0, i_b};
    assign w_sh     = i_b[SW-1:0];
    // Subtraction overflows when operand signs differ and the result sign flips from A.
    assign w_sub_of = (i_a[M-1] != i_b[M-1]) && (w_diff[M-1] != i_a[M-1]);

    // Opcode decode: result, carry/borrow and overflow per operation.
    always_comb begin
        w_res = '0;
        w_cf  = 1'b0;
        w_of  = 1'b0;
        w_ill = 1'b0;
        case (i_op)
            N'(OP_ADD): begin
                w_res = w_sum[M-1:0];
                w_cf  = w_sum[M];
                w_of  = (i_a[M-1] == i_b[M-1]) && (w_sum[M-1] != i_a[M-1]);
            end
            N'(OP_SUB): begin
                w_res = w_diff[M-1:0];
                w_cf  = w_diff[M];
                w_of  = w_sub_of;
            end
            N'(OP_AND): w_res = i_a & i_b;
            N'(OP_OR):  w_res = i_a | i_b;
            N'(OP_XOR): w_res = i_a ^ i_b;
            N'(OP_NOT): w_res = ~i_a;
            N'(OP_SHL): w_res = i_a << w_sh;
            N'(OP_SHR): w_res = i_a >> w_sh;
            // CMP reports A as result; only CF/OF come from A-B, ZF/SF follow the result.
            N'(OP_CMP): begin
                w_res = i_a;
                w_cf  = w_diff[M];
                w_of  = w_sub_of;
            end
            default: w_ill = 1'b1;
        endcase
    end

    // Flag assembly; an illegal opcode forces result and flags to zero.
    always_comb begin
        o_flags = 4'b0000;
        if (w_ill) begin
            o_result = '0;
        end else begin
            o_result         = w_res;
            o_flags[FLAG_ZF] = (w_res == '0);
            o_flags[FLAG_CF] = w_cf;
            o_flags[FLAG_OF] = w_of;
            o_flags[FLAG_SF] = w_res[M-1];
        end
        o_illegal = w_ill;
    end

endmodule

// File: rtl/spi_exe_unit_2.sv
// SPI slave execution unit: receives {opcode, A, B} MSB first, executes the
// operation in one cycle and returns {result, flags} MSB first while chip
// select stays low.
// Ports:
//   i_clk_p       SPI clock, rising edge
//   i_rst_n       synchronous active-low reset
//   i_cs_n        chip select, active-low; going high mid-frame aborts it
//   i_mosi        serial command input
//   o_miso        serial result output, 0 outside transmission
//   o_busy        frame in progress (receive, execute, transmit)
//   o_frame_done  one-cycle pulse after the last result bit
//   o_err         last frame aborted or carried an illegal opcode
module spi_exe_unit_2
    import spi_exe_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 4,
    parameter int F = 4
) (
    input  logic i_clk_p,
    input  logic i_rst_n,
    input  logic i_cs_n,
    input  logic i_mosi,
    output logic o_miso,
    output logic o_busy,
    output logic o_frame_done,
    output logic o_err
);
    localparam int L_IN  = calc_l_in(M, N);
    localparam int L_OUT = calc_l_out(M, F);
    // Counter is shared between RX and TX; L_IN is always the larger length.
    localparam int CW    = $clog2(L_IN + 1);

    logic [2:0]       r_state;
    logic [L_IN-1:0]  r_rx_shift;
    logic [L_OUT-1:0] r_tx_shift;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic             r_err;

    logic [M-1:0]     w_result;
    logic [3:0]       w_flags;
    logic             w_illegal;

    spi_exe_alu #(.M(M), .N(N)) u_alu (
        .i_op      (r_rx_shift[L_IN-1 -: N]),
        .i_a       (r_rx_shift[2*M-1 -: M]),
        .i_b       (r_rx_shift[M-1:0]),
        .o_result  (w_result),
        .o_flags   (w_flags),
        .o_illegal (w_illegal)
    );

    // Frame sequencer: receive, execute, transmit, then wait for chip select release.
    always_ff @(posedge i_clk_p) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!i_cs_n) begin
                        r_rx_shift <= {{(L_IN-1){1'b0}}, i_mosi};
                        r_cnt      <= CW'(1);
                        r_err      <= 1'b0;
                        r_state    <= ST_RX;
                    end
                end
                ST_RX, ST_EXEC, ST_TX: begin
                    if (i_cs_n) begin
                        // Abort: drop everything collected so far.
                        r_rx_shift <= '0;
                        r_tx_shift <= '0;
                        r_cnt      <= '0;
                        r_err      <= 1'b1;
                        r_state    <= ST_IDLE;
                    end else if (r_state == ST_RX) begin
                        r_rx_shift <= {r_rx_shift[L_IN-2:0], i_mosi};
                        r_cnt      <= r_cnt + CW'(1);
                        if (r_cnt == CW'(L_IN - 1)) begin
                            r_state <= ST_EXEC;
                        end
                    end else if (r_state == ST_EXEC) begin
                        r_tx_shift <= {w_result, w_flags};
                        r_cnt      <= '0;
                        r_err      <= w_illegal;
                        r_state    <= ST_TX;
                    end else begin
                        r_tx_shift <= {r_tx_shift[L_OUT-2:0], 1'b0};
                        r_cnt      <= r_cnt + CW'(1);
                        if (r_cnt == CW'(L_OUT - 1)) begin
                            r_done  <= 1'b1;
                            r_state <= ST_WAIT_CS;
                        end
                    end
                end
                ST_WAIT_CS: begin
                    if (i_cs_n) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state only.
    always_comb begin
        o_miso       = (r_state == ST_TX) ? r_tx_shift[L_OUT-1] : 1'b0;
        o_busy       = (r_state == ST_RX) || (r_state == ST_EXEC) || (r_state == ST_TX);
        o_frame_done = r_done;
        o_err        = r_err;
    end

endmodule

// File: tb/tb_spi_exe_unit_2.sv
module tb_spi_exe_unit_2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic cs8, mosi8, miso8, busy8, done8, err8;
    logic cs16, mosi16, miso16, busy16, done16, err16;

    spi_exe_unit_2 #(.M(8), .N(4), .F(4)) dut8 (
        .i_clk_p(clk), .i_rst_n(rst_n), .i_cs_n(cs8), .i_mosi(mosi8),
        .o_miso(miso8), .o_busy(busy8), .o_frame_done(done8), .o_err(err8)
    );

    spi_exe_unit_2 #(.M(16), .N(4), .F(4)) dut16 (
        .i_clk_p(clk), .i_rst_n(rst_n), .i_cs_n(cs16), .i_mosi(mosi16),
        .o_miso(miso16), .o_busy(busy16), .o_frame_done(done16), .o_err(err16)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] fl;
        logic       err;
    } vec_t;

    vec_t vt[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int w, input logic cs, input logic d);
        if (w == 8) begin cs8 = cs; mosi8 = d; end
        else begin cs16 = cs; mosi16 = d; end
    endtask

    // {miso, busy, frame_done, err}
    function automatic logic [3:0] outs(input int w);
        if (w == 8) return {miso8, busy8, done8, err8};
        return {miso16, busy16, done16, err16};
    endfunction

    function automatic logic [35:0] mk(input int w, input longint op, input longint a, input longint b);
        longint v;
        if (w == 8) v = (op << 16) | (a << 8) | b;
        else        v = (op << 32) | (a << 16) | b;
        return v[35:0];
    endfunction

    // Reference model straight from the operation definitions, using integer arithmetic.
    function automatic void model(input int m, input int op, input longint a, input longint b,
                                  output longint res, output int fl, output bit ill);
        longint full, half, mask, sa, sb, t;
        bit cf, of;
        full = longint'(1) << m;
        half = full / 2;
        mask = full - 1;
        sa = (a >= half) ? a - full : a;
        sb = (b >= half) ? b - full : b;
        cf = 1'b0; of = 1'b0; ill = 1'b0; res = 0;
        case (op)
            0: begin t = a + b; res = t % full; cf = (t >= full);
                     of = (sa + sb > half - 1) || (sa + sb < -half); end
            1, 8: begin t = a - b; res = (op == 1) ? ((t + full) % full) : a; cf = (a < b);
                     of = (sa - sb > half - 1) || (sa - sb < -half); end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = mask - a;
            6: res = (a * (longint'(1) << (b % m))) % full;
            7: res = a / (longint'(1) << (b % m));
            default: ill = 1'b1;
        endcase
        if (ill) fl = 0;
        else fl = ((res == 0) ? 8 : 0) + (cf ? 4 : 0) + (of ? 2 : 0) + ((res >= half) ? 1 : 0);
    endfunction

    // Full frame with cs low throughout; optionally keeps cs low `hold` extra cycles.
    task automatic run_frame(input int w, input logic [35:0] fr, input int hold,
                             output logic [19:0] got, output int ndone, output logic err_end,
                             output logic done_end, output int miso_hold);
        logic [3:0] o;
        int lin, lout;
        lin  = (w == 8) ? 20 : 36;
        lout = (w == 8) ? 12 : 20;
        got = '0; ndone = 0; miso_hold = 0;
        for (int i = 0; i < lin; i++) begin
            @(negedge clk);
            o = outs(w);
            if (o[1]) ndone++;
            drive(w, 1'b0, fr[lin-1-i]);
        end
        @(negedge clk);
        o = outs(w);
        check("exec_busy", {63'd0, o[2]}, 64'd1);
        drive(w, 1'b0, 1'b0);
        for (int j = 0; j < lout; j++) begin
            @(negedge clk);
            o = outs(w);
            got = {got[18:0], o[3]};
            if (o[1]) ndone++;
        end
        @(negedge clk);
        o = outs(w);
        done_end = o[1];
        err_end  = o[0];
        if (o[1]) ndone++;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            o = outs(w);
            if (o[3]) miso_hold++;
            if (o[1]) ndone++;
        end
        drive(w, 1'b1, 1'b0);
        @(negedge clk);
        o = outs(w);
        check("idle_after_frame", {60'd0, o[3:2]}, 64'd0);
    endtask

    initial begin
        logic [19:0] got;
        logic [35:0] fr;
        logic        err_end, done_end;
        int          ndone, mh, fl, op;
        longint      res, a, b;
        bit          ill;

        vt[0]  = '{"add_7f_01",  4'h0, 8'h7F, 8'h01, 8'h80, 4'b0011, 1'b0};
        vt[1]  = '{"sub_eq",     4'h1, 8'h05, 8'h05, 8'h00, 4'b1000, 1'b0};
        vt[2]  = '{"cmp_3_9",    4'h8, 8'h03, 8'h09, 8'h03, 4'b0100, 1'b0};
        vt[3]  = '{"add_1_2",    4'h0, 8'h01, 8'h02, 8'h03, 4'b0000, 1'b0};
        vt[4]  = '{"illegal_f",  4'hF, 8'hAA, 8'h55, 8'h00, 4'b0000, 1'b1};
        vt[5]  = '{"and",        4'h2, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0};
        vt[6]  = '{"or_zero",    4'h3, 8'h00, 8'h00, 8'h00, 4'b1000, 1'b0};
        vt[7]  = '{"xor",        4'h4, 8'hFF, 8'h0F, 8'hF0, 4'b0001, 1'b0};
        vt[8]  = '{"not",        4'h5, 8'h0F, 8'h77, 8'hF0, 4'b0001, 1'b0};
        vt[9]  = '{"shl_1",      4'h6, 8'h81, 8'h01, 8'h02, 4'b0000, 1'b0};
        vt[10] = '{"shr_7",      4'h7, 8'h80, 8'hFF, 8'h01, 4'b0000, 1'b0};
        vt[11] = '{"add_carry",  4'h0, 8'hFF, 8'h01, 8'h00, 4'b1100, 1'b0};
        vt[12] = '{"sub_ovf",    4'h1, 8'h80, 8'h01, 8'h7F, 4'b0010, 1'b0};

        rst_n = 1'b0;
        drive(8, 1'b1, 1'b0);
        drive(16, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("reset_outs8", {60'd0, outs(8)}, 64'd0);
        check("reset_outs16", {60'd0, outs(16)}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table.
        foreach (vt[i]) begin
            run_frame(8, mk(8, vt[i].op, vt[i].a, vt[i].b), 0, got, ndone, err_end, done_end, mh);
            check({vt[i].name, "_res"},  {52'd0, got[11:0]}, {52'd0, vt[i].res, vt[i].fl});
            check({vt[i].name, "_err"},  {63'd0, err_end}, {63'd0, vt[i].err});
            check({vt[i].name, "_done"}, {63'd0, done_end}, 64'd1);
            check({vt[i].name, "_ndone"}, 64'(ndone), 64'd1);
        end

        // Abort after 10 received bits, then a clean frame.
        fr = mk(8, 0, 8'h01, 8'h02);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(8, 1'b0, fr[19-i]);
        end
        @(negedge clk);
        drive(8, 1'b1, 1'b0);
        @(negedge clk);
        check("abort_outs", {60'd0, outs(8)}, 64'd1);
        ndone = 0; mh = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done8) ndone++;
            if (miso8) mh++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        check("abort_miso", 64'(mh), 64'd0);
        run_frame(8, fr, 0, got, ndone, err_end, done_end, mh);
        check("after_abort_res", {52'd0, got[11:0]}, {52'd0, 8'h03, 4'b0000});
        check("after_abort_err", {63'd0, err_end}, 64'd0);

        // Chip select held low after the frame.
        run_frame(8, mk(8, 0, 8'h7F, 8'h01), 40, got, ndone, err_end, done_end, mh);
        check("hold_ndone", 64'(ndone), 64'd1);
        check("hold_miso", 64'(mh), 64'd0);

        // Reset in the middle of transmission of an illegal-opcode frame.
        fr = mk(8, 15, 8'hAA, 8'h55);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(8, 1'b0, fr[19-i]);
        end
        @(negedge clk);
        drive(8, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("pre_rst_busy_err", {62'd0, outs(8) & 4'b0101}, 64'd5);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_tx", {60'd0, outs(8)}, 64'd0);
        rst_n = 1'b1;
        drive(8, 1'b1, 1'b0);
        @(negedge clk);
        check("post_rst_idle", {60'd0, outs(8)}, 64'd0);

        // Wide instance: 36-bit inbound, 20-bit outbound.
        run_frame(16, mk(16, 6, 16'h0001, 16'h000F), 0, got, ndone, err_end, done_end, mh);
        check("m16_shl15", {44'd0, got}, {44'd0, 16'h8000, 4'b0001});
        check("m16_done", 64'(ndone), 64'd1);

        // Randomised frames against the reference model.
        for (int r = 0; r < 40; r++) begin
            op = int'($urandom_range(0, 15));
            a  = longint'($urandom_range(0, 255));
            b  = longint'($urandom_range(0, 255));
            model(8, op, a, b, res, fl, ill);
            run_frame(8, mk(8, op, a, b), 0, got, ndone, err_end, done_end, mh);
            check("rand8_res", {52'd0, got[11:0]}, 64'((res << 4) | fl));
            check("rand8_err", {63'd0, err_end}, {63'd0, ill});
            check("rand8_done", 64'(ndone), 64'd1);
        end
        for (int r = 0; r < 12; r++) begin
            op = int'($urandom_range(0, 10));
            a  = longint'($urandom_range(0, 65535));
            b  = longint'($urandom_range(0, 65535));
            model(16, op, a, b, res, fl, ill);
            run_frame(16, mk(16, op, a, b), 0, got, ndone, err_end, done_end, mh);
            check("rand16_res", {44'd0, got}, 64'((res << 4) | fl));
            check("rand16_err", {63'd0, err_end}, {63'd0, ill});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
